// File: rtl/rect_draw_ctrl.sv
// Rectangle draw controller: loads x0/y0/w/h from a shared bus, then scans the rectangle row-major, one pixel per clock.
// Optional outline-only plotting is enabled by defining RECT_OUTLINE_EN.
module rect_draw_ctrl #(
  parameter int X_W    = 8,
  parameter int Y_W    = 7,
  parameter int SIZE_W = 4,
  parameter int COL_W  = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             draw,
  input  logic             outline,
  input  logic [X_W-1:0]   data_in,
  input  logic [COL_W-1:0] colour_in,
  output logic [X_W-1:0]   x_out,
  output logic [Y_W-1:0]   y_out,
  output logic [COL_W-1:0] colour_out,
  output logic             plot,
  output logic             busy,
  output logic             done,
  output logic [3:0]       current_state
);

  typedef enum logic [3:0] {
    S_LOAD_X    = 4'd0,
    S_WAIT_X    = 4'd1,
    S_LOAD_Y    = 4'd2,
    S_WAIT_Y    = 4'd3,
    S_LOAD_W    = 4'd4,
    S_WAIT_W    = 4'd5,
    S_LOAD_H    = 4'd6,
    S_WAIT_H    = 4'd7,
    S_WAIT_DRAW = 4'd8,
    S_DRAW      = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  state_t            state;
  logic [X_W-1:0]    x0;
  logic [Y_W-1:0]    y0;
  logic [SIZE_W-1:0] w;
  logic [SIZE_W-1:0] h;
  logic [COL_W-1:0]  colour;
  logic [SIZE_W-1:0] col;
  logic [SIZE_W-1:0] row;
  logic              last_col;
  logic              last_row;

  assign last_col = (col == w - 1'b1);
  assign last_row = (row == h - 1'b1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_LOAD_X;
      x0     <= '0;
      y0     <= '0;
      w      <= '0;
      h      <= '0;
      colour <= '0;
      col    <= '0;
      row    <= '0;
    end else begin
      case (state)
        S_LOAD_X: begin
          x0 <= data_in;
          if (enable) state <= S_WAIT_X;
        end
        S_WAIT_X: if (!enable) state <= S_LOAD_Y;
        S_LOAD_Y: begin
          y0 <= data_in[Y_W-1:0];
          if (enable) state <= S_WAIT_Y;
        end
        S_WAIT_Y: if (!enable) state <= S_LOAD_W;
        S_LOAD_W: begin
          w <= data_in[SIZE_W-1:0];
          if (enable) state <= S_WAIT_W;
        end
        S_WAIT_W: if (!enable) state <= S_LOAD_H;
        S_LOAD_H: begin
          h <= data_in[SIZE_W-1:0];
          if (enable) state <= S_WAIT_H;
        end
        S_WAIT_H: if (!enable) state <= S_WAIT_DRAW;
        S_WAIT_DRAW: begin
          if (draw) begin
            colour <= colour_in;
            col    <= '0;
            row    <= '0;
            // A degenerate rectangle skips the scan entirely
            state  <= (w == '0 || h == '0) ? S_DONE : S_DRAW;
          end
        end
        S_DRAW: begin
          if (last_col) begin
            col <= '0;
            if (last_row) state <= S_DONE;
            else          row   <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        S_DONE:  state <= S_LOAD_X;
        default: state <= S_LOAD_X;
      endcase
    end
  end

  assign x_out         = x0 + X_W'(col);
  assign y_out         = y0 + Y_W'(row);
  assign colour_out    = colour;
  assign busy          = (state == S_DRAW) || (state == S_DONE);
  assign done          = (state == S_DONE);
  assign current_state = state;

`ifdef RECT_OUTLINE_EN
  logic border;
  assign border = (col == '0) || last_col || (row == '0) || last_row;
  assign plot   = (state == S_DRAW) && (!outline || border);
`else
  logic unused_outline;
  assign unused_outline = outline;
  assign plot           = (state == S_DRAW);
`endif

endmodule
